vproc_div_elem_seq: RTL

VPROC_DIV_ELEM_SEQ -- requirements
Module: vproc_div_elem_seq

---
 rtl/vproc_div_elem_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/vproc_div_elem_seq.sv
// vproc_div_elem_seq: splits packed SEW lanes into sequential 32-bit requests to an external divider
module vproc_div_elem_seq #(
    parameter int unsigned DIV_LAT = 0
) (
    input  logic        clk_i,
    input  logic        sync_rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_op1_i,
    input  logic [31:0] in_op2_i,
    input  logic [1:0]  in_sew_i,
    input  logic        in_signed_i,
    input  logic        in_mod_i,
    output logic        div_mod_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [31:0] div_res_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_res_o,
    output logic        out_err_o
);
    localparam logic [1:0] LAT = 2'(DIV_LAT);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state;
    logic [31:0] op1, op2, res;
    logic [1:0]  sew, idx, cnt, last;
    logic        sgn, md, err, ready, valid, bad;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    assign bad = in_sew_i == 2'b11 || (in_sew_i == 2'b10 && !in_signed_i);
    assign last = sew == 2'b00 ? 2'd3 : sew == 2'b01 ? 2'd1 : 2'd0;
    assign a8 = op1[{idx, 3'b000} +: 8];
    assign b8 = op2[{idx, 3'b000} +: 8];
    assign a16 = op1[{idx[0], 4'b0000} +: 16];
    assign b16 = op2[{idx[0], 4'b0000} +: 16];
    assign div_op1_o = state != BUSY ? '0 : sew == 2'b00 ? {{24{sgn & a8[7]}}, a8} :
                       sew == 2'b01 ? {{16{sgn & a16[15]}}, a16} : op1;
    assign div_op2_o = state != BUSY ? '0 : sew == 2'b00 ? {{24{sgn & b8[7]}}, b8} :
                       sew == 2'b01 ? {{16{sgn & b16[15]}}, b16} : op2;
    assign div_mod_o = md;
    assign in_ready_o = ready;
    assign out_valid_o = valid;
    assign out_res_o = res;
    assign out_err_o = err;
    // an error request spends one BUSY cycle without touching the divider before DONE
    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            state <= IDLE;
            op1   <= '0;
            op2   <= '0;
            res   <= '0;
            sew   <= '0;
            idx   <= '0;
            cnt   <= '0;
            sgn   <= 1'b0;
            md    <= 1'b0;
            err   <= 1'b0;
            ready <= 1'b1;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    op1   <= in_op1_i;
                    op2   <= in_op2_i;
                    sew   <= in_sew_i;
                    sgn   <= in_signed_i;
                    md    <= in_mod_i;
                    idx   <= '0;
                    cnt   <= '0;
                    res   <= '0;
                    err   <= bad;
                    ready <= 1'b0;
                    state <= BUSY;
                end
                BUSY: if (err) begin
                    state <= DONE;
                    valid <= 1'b1;
                end else if (cnt != LAT) begin
                    cnt <= cnt + 2'd1;
                end else begin
                    if (sew == 2'b00) res[{idx, 3'b000} +: 8] <= div_res_i[7:0];
                    else if (sew == 2'b01) res[{idx[0], 4'b0000} +: 16] <= div_res_i[15:0];
                    else res <= div_res_i;
                    cnt <= '0;
                    if (idx == last) begin
                        state <= DONE;
                        valid <= 1'b1;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                DONE: if (out_ready_i) begin
                    state <= IDLE;
                    valid <= 1'b0;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
